ps2_keyboard_rx: RTL

- Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` pins.
- Strips the E0 (extended) and F0 (break) prefixes and delivers a complete key event to the game processor: `keycode`, `make`, and a one-cycle `keycode_ready` strobe.
- Sits directly upstream of the processor. It is the only block that touches the keyboard pins.

---
 rtl/ps2_pkg.sv | 13 +
 rtl/ps2_frame_rx.sv | 143 ++++++++++++++
 rtl/ps2_keyboard_rx.sv | 71 +++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and frame state type for the PS/2 keyboard receiver
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
    localparam int         PS2_FRAME_BITS   = 11;

    typedef enum logic {
        IDLE,
        SHIFT
    } ps2_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 frame receiver: sync, edge detect, shift, timeout; optional parity check under PS2_PARITY_CHECK_EN
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int         CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [3:0] STOP_IDX = 4'(PS2_FRAME_BITS - 1);
    localparam logic [3:0] LAST_DAT = 4'd8;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    ps2_state_e state, state_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic [CW-1:0] idle_cnt, idle_cnt_n;
    logic          frame_ok;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    assign byte_data = shreg;

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit, par_bit_n;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    assign frame_ok = data_s & (^{shreg, par_bit});

    // Parity bit register, only present when parity is checked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_bit <= 1'b0;
        end else begin
            par_bit <= par_bit_n;
        end
    end
`else
    assign frame_ok = data_s;
`endif

    // Synchronizers idle high so reset never manufactures a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= {SYNC_STAGES{1'b1}};
            data_sync <= {SYNC_STAGES{1'b1}};
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    // Frame state, bit counter, shift register and idle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            shreg    <= 8'h00;
            idle_cnt <= '0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            idle_cnt <= idle_cnt_n;
        end
    end

    // Next-state logic; a falling edge always wins over the timeout.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        idle_cnt_n = idle_cnt;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_bit_n  = par_bit;
`endif
        case (state)
            IDLE: begin
                idle_cnt_n = '0;
                if (fall && !data_s) begin
                    state_n   = SHIFT;
                    bit_cnt_n = 4'd1;
                end
            end
            SHIFT: begin
                if (fall) begin
                    idle_cnt_n = '0;
                    if (bit_cnt == STOP_IDX) begin
                        state_n   = IDLE;
                        bit_cnt_n = 4'd0;
                        if (frame_ok) begin
                            byte_valid = 1'b1;
                        end else begin
                            frame_err = 1'b1;
                        end
                    end else begin
                        if (bit_cnt <= LAST_DAT) begin
                            shreg_n = {data_s, shreg[7:1]};
                        end
`ifdef PS2_PARITY_CHECK_EN
                        else begin
                            par_bit_n = data_s;
                        end
`endif
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end else if (idle_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_n    = IDLE;
                    bit_cnt_n  = 4'd0;
                    idle_cnt_n = '0;
                    frame_err  = 1'b1;
                end else begin
                    idle_cnt_n = idle_cnt + 1'b1;
                end
            end
            default: begin
                state_n   = IDLE;
                bit_cnt_n = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard receiver top: prefix decoder and key event outputs (PS2_PARITY_CHECK_EN enables parity check)
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       make,
    output logic       extended,
    output logic       keycode_ready,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    logic       ext_flag;
    logic       brk_flag;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_frame_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_data  (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (rx_err)
    );

    // Prefix decoder: accumulate E0/F0 flags, emit one event per real scan code.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            keycode       <= 8'h00;
            make          <= 1'b0;
            extended      <= 1'b0;
            keycode_ready <= 1'b0;
            frame_err     <= 1'b0;
            ext_flag      <= 1'b0;
            brk_flag      <= 1'b0;
        end else begin
            keycode_ready <= 1'b0;
            frame_err     <= rx_err;
            if (rx_err) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == PS2_EXT_PREFIX) begin
                    ext_flag <= 1'b1;
                end else if (rx_byte == PS2_BREAK_PREFIX) begin
                    brk_flag <= 1'b1;
                end else begin
                    keycode       <= rx_byte;
                    make          <= ~brk_flag;
                    extended      <= ext_flag;
                    keycode_ready <= 1'b1;
                    ext_flag      <= 1'b0;
                    brk_flag      <= 1'b0;
                end
            end
        end
    end

endmodule
